issue_mem_queue: RTL

- In-order issue buffer for the MEM pipe, directly downstream of the dispatch pipeline registers.
- Accepts dispatched micro-ops tagged for the MEM pipe.
- Resolves ALU-forwarded operands at enqueue time.
- Holds up to DEPTH entries and hands them one at a time to the memory address/access stage over a valid/ready handshake.
- Flushed entirely on branch commit override (bco_valid).

---
 rtl/core_dispatch_pkg.sv | 17 +
 rtl/issue_mem_queue_ptr.sv | 51 +++++
 rtl/issue_mem_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/core_dispatch_pkg.sv
// Shared dispatch-side widths and the MEM issue-queue entry layout.
package core_dispatch_pkg;
    localparam int DATA_W    = 32;
    localparam int ROB_TAG_W = 4;
    localparam int FID_W     = 8;
    localparam int IMM_W     = 26;
    localparam int MEM_CMD_W = 5;

    typedef struct packed {
        logic [DATA_W-1:0]    src0;
        logic [DATA_W-1:0]    src1;
        logic [ROB_TAG_W-1:0] rob;
        logic [IMM_W-1:0]     imm;
        logic [FID_W-1:0]     fid;
        logic [MEM_CMD_W-1:0] mem_cmd;
    } mem_entry_t;
endpackage

// File: rtl/issue_mem_queue_ptr.sv
// Read/write pointers and occupancy for the MEM issue queue; flush clears all state.
module issue_mem_queue_ptr #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_flush,
    input  logic             i_enq,
    input  logic             i_deq,
    output logic [PTR_W-1:0] o_rptr,
    output logic [PTR_W-1:0] o_wptr,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W:0]   r_count;

    // Pointer and count state; DEPTH is a power of two so wrap is natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rptr  <= {PTR_W{1'b0}};
            r_wptr  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else if (i_flush) begin
            r_rptr  <= {PTR_W{1'b0}};
            r_wptr  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else begin
            if (i_enq) begin
                r_wptr <= r_wptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (i_deq) begin
                r_rptr <= r_rptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PTR_W{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rptr  = r_rptr;
    assign o_wptr  = r_wptr;
    assign o_count = r_count;
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == {(PTR_W+1){1'b0}});
endmodule

// File: rtl/issue_mem_queue.sv
// In-order MEM-pipe issue buffer with enqueue-time ALU forwarding.
// Optional same-cycle empty-queue bypass under `ISSUE_MEM_QUEUE_BYPASS_EN.
module issue_mem_queue
    import core_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 bco_valid,
    input  logic                 i_valid,
    input  logic                 i_pipe_mem,
    input  logic [DATA_W-1:0]    i_src0_value,
    input  logic                 i_src0_forward_alu,
    input  logic [DATA_W-1:0]    i_src1_value,
    input  logic                 i_src1_forward_alu,
    input  logic [DATA_W-1:0]    i_alu_result,
    input  logic [ROB_TAG_W-1:0] i_dst_rob,
    input  logic [IMM_W-1:0]     i_imm,
    input  logic [FID_W-1:0]     i_fid,
    input  logic [MEM_CMD_W-1:0] i_mem_cmd,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_W-1:0]    o_src0_value,
    output logic [DATA_W-1:0]    o_src1_value,
    output logic [ROB_TAG_W-1:0] o_dst_rob,
    output logic [IMM_W-1:0]     o_imm,
    output logic [FID_W-1:0]     o_fid,
    output logic [MEM_CMD_W-1:0] o_mem_cmd,
    output logic [PTR_W:0]       o_count
);
    logic [PTR_W-1:0] w_rptr;
    logic [PTR_W-1:0] w_wptr;
    logic [PTR_W:0]   w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic             w_bypass;
    logic             w_write;
    mem_entry_t       w_in;
    mem_entry_t       w_head;
    mem_entry_t       r_mem [DEPTH];

    assign w_enq = i_valid & i_pipe_mem & ~w_full & ~bco_valid;
    assign w_deq = ~w_empty & i_ready & ~bco_valid;
`ifdef ISSUE_MEM_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & w_enq & i_ready;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_write = w_enq & ~w_bypass;

    assign w_in.src0    = i_src0_forward_alu ? i_alu_result : i_src0_value;
    assign w_in.src1    = i_src1_forward_alu ? i_alu_result : i_src1_value;
    assign w_in.rob     = i_dst_rob;
    assign w_in.imm     = i_imm;
    assign w_in.fid     = i_fid;
    assign w_in.mem_cmd = i_mem_cmd;

    issue_mem_queue_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (bco_valid),
        .i_enq   (w_write),
        .i_deq   (w_deq),
        .o_rptr  (w_rptr),
        .o_wptr  (w_wptr),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Entry storage; flush leaves payload in place since the pointers gate it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {$bits(mem_entry_t){1'b0}};
            end
        end else if (w_write) begin
            r_mem[w_wptr] <= w_in;
        end else begin
            r_mem[w_wptr] <= r_mem[w_wptr];
        end
    end

    // Head selection: stored entry at rptr, or the live input when bypassing.
    always_comb begin
        w_head  = r_mem[w_rptr];
        o_valid = ~w_empty;
        if (w_bypass) begin
            w_head  = w_in;
            o_valid = 1'b1;
        end else begin
            w_head  = r_mem[w_rptr];
            o_valid = ~w_empty;
        end
    end

    assign o_ready      = ~w_full;
    assign o_count      = w_count;
    assign o_src0_value = w_head.src0;
    assign o_src1_value = w_head.src1;
    assign o_dst_rob    = w_head.rob;
    assign o_imm        = w_head.imm;
    assign o_fid        = w_head.fid;
    assign o_mem_cmd    = w_head.mem_cmd;
endmodule
